// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants for the RV32I multicycle control unit
//
// Purpose: state encodings, opcode constants, datapath mux codes and branch
// funct3 values shared by mc_next_state and mc_control_fsm.
// Ports: none (package).
package mc_pkg;

  // State encodings (5-bit; 21..31 are unreachable).
  localparam logic [4:0] S_FETCH  = 5'd0;
  localparam logic [4:0] S_DECODE = 5'd1;
  localparam logic [4:0] S_MEMADR = 5'd2;
  localparam logic [4:0] S_MEMRD  = 5'd3;
  localparam logic [4:0] S_MEMWB  = 5'd4;
  localparam logic [4:0] S_MEMWR  = 5'd5;
  localparam logic [4:0] S_EXEC_R = 5'd6;
  localparam logic [4:0] S_WB_R   = 5'd7;
  localparam logic [4:0] S_BEQ    = 5'd8;
  localparam logic [4:0] S_EXEC_I = 5'd9;
  localparam logic [4:0] S_WB_I   = 5'd10;
  localparam logic [4:0] S_JAL    = 5'd11;
  localparam logic [4:0] S_JALR   = 5'd12;
  localparam logic [4:0] S_BNE    = 5'd13;
  localparam logic [4:0] S_BLT    = 5'd14;
  localparam logic [4:0] S_BGE    = 5'd15;
  localparam logic [4:0] S_BLTU   = 5'd16;
  localparam logic [4:0] S_BGEU   = 5'd17;
  localparam logic [4:0] S_AUIPC  = 5'd18;
  localparam logic [4:0] S_LUI    = 5'd19;
  localparam logic [4:0] S_TRAP   = 5'd20;

  // Major opcodes, IR[6:0].
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALUOp codes.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB codes.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // PCSource codes.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  // MemtoReg codes.
  localparam logic [1:0] MTR_ALU   = 2'b00;
  localparam logic [1:0] MTR_MEM   = 2'b01;
  localparam logic [1:0] MTR_IMM   = 2'b10;
  localparam logic [1:0] MTR_PCIMM = 2'b11;

  // Branch funct3 values.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/mc_next_state.sv
// rtl/mc_next_state.sv - combinational next-state logic for the multicycle control unit
//
// Purpose: computes the next state from the current state, the instruction
// register fields and the (already qualified) memory-ready strobe. An illegal
// opcode/funct3 seen in DECODE is flagged on decode_illegal and steered to
// S_TRAP; the parent decides whether to honour the trap.
// Ports:
//   state          in  5  current state
//   opcode         in  7  IR[6:0]
//   funct3         in  3  IR[14:12]
//   mem_ok         in  1  memory access completes this cycle
//   next_state     out 5  state for the next clock
//   decode_illegal out 1  DECODE sees an unsupported opcode/funct3
module mc_next_state
  import mc_pkg::*;
(
  input  logic [4:0] state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ok,
  output logic [4:0] next_state,
  output logic       decode_illegal
);

  always_comb begin
    next_state     = S_FETCH;
    decode_illegal = 1'b0;
    case (state)
      S_FETCH:  next_state = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_LUI:            next_state = S_LUI;
          OP_BRANCH: begin
            case (funct3)
              F3_BEQ:  next_state = S_BEQ;
              F3_BNE:  next_state = S_BNE;
              F3_BLT:  next_state = S_BLT;
              F3_BGE:  next_state = S_BGE;
              F3_BLTU: next_state = S_BLTU;
              F3_BGEU: next_state = S_BGEU;
              default: begin
                decode_illegal = 1'b1;
                next_state     = S_TRAP;
              end
            endcase
          end
          default: begin
            decode_illegal = 1'b1;
            next_state     = S_TRAP;
          end
        endcase
      end
      // Opcode is still stable here, so it distinguishes load from store.
      S_MEMADR: next_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC_R: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_TRAP:   next_state = S_TRAP;
      // MEMWB, WB_R, WB_I, branches, JAL, JALR, AUIPC, LUI, and any
      // unreachable encoding all return to FETCH.
      default:  next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - RV32I multicycle control unit with handshake, trap and retire counter
//
// Purpose: state register, next-state selection and Moore-decoded datapath
// controls for the multicycle core, plus a retired-instruction counter.
// Parameters: MEM_HANDSHAKE (wait on mem_ready), TRAP_EN (illegal -> TRAP
// vs. NOP), CNT_W (retire_count width), NCOND (pc_write_cond width).
// Ports:
//   clk, reset                 in   clock, synchronous active-high reset
//   opcode[6:0], funct3[2:0]   in   instruction register fields
//   mem_ready                  in   memory completes current access
//   RegWrite ALUSrcA MemRead MemWrite IorD IRWrite PCWrite  out 1 each
//   ALUOp ALUSrcB PCSource MemtoReg                         out 2 each
//   pc_write_cond[NCOND-1:0]   out  one-hot branch-type write condition
//   state[4:0]                 out  current state
//   illegal                    out  high while in TRAP
//   retire_pulse               out  instruction completes this cycle
//   retire_count[CNT_W-1:0]    out  completed instruction count (wraps)
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned TRAP_EN       = 1,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned NCOND         = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       MemtoReg,
  output logic [NCOND-1:0] pc_write_cond,
  output logic [4:0]       state,
  output logic             illegal,
  output logic             retire_pulse,
  output logic [CNT_W-1:0] retire_count
);

  logic [4:0]       state_q;
  logic [4:0]       state_d;
  logic [CNT_W-1:0] retire_count_q;
  logic [CNT_W-1:0] retire_count_d;
  logic [4:0]       ns_next;
  logic             ns_illegal;
  logic             mem_ok;
  logic [5:0]       cond6;

  // Without the handshake every memory access completes in one cycle.
  assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  mc_next_state u_next_state (
    .state          (state_q),
    .opcode         (opcode),
    .funct3         (funct3),
    .mem_ok         (mem_ok),
    .next_state     (ns_next),
    .decode_illegal (ns_illegal)
  );

  // Next-state selection: with traps disabled an illegal instruction is a NOP.
  always_comb begin
    state_d = ns_next;
    if (ns_illegal && (TRAP_EN == 0)) begin
      state_d = S_FETCH;
    end
  end

  // An instruction retires when any in-flight (non-FETCH, non-TRAP) state
  // hands back to FETCH; reset discards the instruction without retiring.
  always_comb begin
    retire_pulse   = !reset && (state_q != S_FETCH) && (state_q != S_TRAP) &&
                     (state_d == S_FETCH);
    retire_count_d = retire_pulse ? retire_count_q + CNT_W'(1) : retire_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_FETCH;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Output decode.
  always_comb begin
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUOp    = ALUOP_ADD;
    ALUSrcB  = SRCB_REG;
    PCSource = PCSRC_ALU;
    MemtoReg = MTR_ALU;
    cond6    = 6'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC latch only on the cycle the fetch actually completes.
        IRWrite = mem_ok;
        PCWrite = mem_ok;
      end
      S_DECODE: ALUSrcB = SRCB_IMM;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_MEM;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_WB_R, S_WB_I: RegWrite = 1'b1;
      S_BEQ, S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_CMP;
        PCSource = PCSRC_TARGET;
        case (state_q)
          S_BEQ:   cond6 = 6'b000001;
          S_BNE:   cond6 = 6'b000010;
          S_BLT:   cond6 = 6'b000100;
          S_BGE:   cond6 = 6'b001000;
          S_BLTU:  cond6 = 6'b010000;
          default: cond6 = 6'b100000;
        endcase
      end
      S_JAL, S_JALR: begin
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = (state_q == S_JALR) ? PCSRC_JALR : PCSRC_TARGET;
      end
      S_AUIPC: begin
        RegWrite = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        MemtoReg = MTR_PCIMM;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        MemtoReg = MTR_IMM;
      end
      default: ;  // TRAP and unreachable encodings drive nothing
    endcase
    if (reset) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      cond6    = 6'b0;
    end
  end

  assign pc_write_cond = NCOND'(cond6);
  assign state         = state_q;
  assign illegal       = (state_q == S_TRAP);
  assign retire_count  = retire_count_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control unit for the RV32I multicycle core: state register, next-state logic and state-decoded datapath controls in one block. It replaces the standalone state-to-control decoder. It adds:
- a variable-latency memory handshake;
- branch-condition decode from funct3;
- an illegal-instruction trap state;
- a retired-instruction counter.

It sits between the instruction register (opcode/funct3) and the datapath muxes and enables.

## Interface
Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1)
- TRAP_EN, 1: 1 = illegal opcode/funct3 enters sticky TRAP; 0 = treated as NOP (DECODE→FETCH)
- CNT_W, 32: width of retire_count
- NCOND, 6: width of pc_write_cond (one bit per branch type)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0], stable from DECODE until next FETCH
- funct3  in  3  IR[14:12]
- mem_ready  in  1  memory completes the current access this cycle
- RegWrite, ALUSrcA, MemRead, MemWrite, IorD, IRWrite, PCWrite  out  1 each
- ALUOp, ALUSrcB, PCSource, MemtoReg  out  2 each
- pc_write_cond  out  NCOND  bit0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU
- state  out  5  current state (debug)
- illegal  out  1  high while in TRAP
- retire_pulse  out  1  one cycle per completed instruction
- retire_count  out  CNT_W  completed instructions, wraps modulo 2^CNT_W

## Operation
States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, WB_R 7, BEQ 8, EXEC_I 9, WB_I 10, JAL 11, JALR 12, BNE 13, BLT 14, BGE 15, BLTU 16, BGEU 17, AUIPC 18, LUI 19, TRAP 20. Encodings 21–31 are unreachable; if entered, go to FETCH next cycle with all outputs 0.

Transitions:
- FETCH→DECODE on mem_ready, else hold.
- DECODE dispatch by opcode:
  - 0000011 and 0100011→MEMADR
  - 0110011→EXEC_R
  - 0010011→EXEC_I
  - 1100011→branch state by funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal)
  - 1101111→JAL, 1100111→JALR, 0010111→AUIPC, 0110111→LUI
  - any other opcode is illegal
- MEMADR→MEMRD if opcode is load, else MEMWR.
- MEMRD→MEMWB on mem_ready, else hold. MEMWR→FETCH on mem_ready, else hold.
- EXEC_R→WB_R→FETCH. EXEC_I→WB_I→FETCH.
- Branch, JAL, JALR, AUIPC, LUI, MEMWB→FETCH.
- TRAP→TRAP until reset.

Outputs are Moore-decoded from state. Every signal not listed below is 0.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1.
- DECODE: ALUSrcB=10. MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1, MemRead=1. MEMWB: RegWrite=1, MemtoReg=01.
- MEMWR: IorD=1, MemWrite=1.
- EXEC_R: ALUSrcA=1, ALUOp=10. EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10.
- WB_R / WB_I: RegWrite=1.
- Branch states: ALUSrcA=1, ALUOp=01, PCSource=10, pc_write_cond=one-hot bit of that branch.
- JAL: PCWrite=1, RegWrite=1, PCSource=10, ALUSrcB=01.
- JALR: same as JAL but PCSource=11.
- AUIPC: RegWrite=1, ALUSrcB=01, MemtoReg=11. LUI: same but MemtoReg=10.
- TRAP: illegal=1.

Retire counter:
- retire_pulse=1 on any cycle whose next state is FETCH from a non-FETCH, non-TRAP state.
- Illegal-as-NOP (TRAP_EN=0) also retires.
- retire_count increments in the same edge.

## Timing
- Reset: state=FETCH, retire_count=0, retire_pulse=0. While reset=1, all write enables (RegWrite, MemWrite, IRWrite, PCWrite, pc_write_cond) are forced to 0.
- Reset mid-instruction discards the instruction without a retire pulse.
- Reset dominates mem_ready in the same cycle.
- Cycles with zero wait: branch/JAL/JALR/LUI/AUIPC 3, R/I-type 4, store 4, load 5. Each wait cycle at FETCH/MEMRD/MEMWR adds 1.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored. MemRead/MemWrite are held stable during a wait.
- retire_count wraps from all-ones to 0 without a flag.

## Structure
- Shared package mc_pkg:
  - state encoding localparams (S_FETCH…S_TRAP)
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI)
  - ALUOp / ALUSrcB / PCSource / MemtoReg code constants
  - branch funct3 constants
- Sub-module mc_next_state (combinational): state, opcode, funct3, mem_ready → next state, illegal detect.
- Output decode and retire counter stay in the top.

## Test plan
- R-type add (opcode 0110011), mem_ready=1: states 0,1,6,7,0. RegWrite only in state 7. retire_count 0→1.
- Load with MEM_HANDSHAKE=1, mem_ready low for 3 cycles in MEMRD: MEMRD held 4 cycles with IorD=MemRead=1. Total 8 cycles. MemtoReg=01 in MEMWB.
- BLTU (1100011, funct3 110): state 16, pc_write_cond=6'b010000, PCSource=10. Next state FETCH after 3 cycles.
- Illegal opcode 0000000 with TRAP_EN=1: TRAP, illegal=1 held for 10 cycles. retire_count unchanged. Reset returns to FETCH with count 0.
- Illegal branch funct3 010 with TRAP_EN=0: DECODE→FETCH, retire_pulse=1, no write enables asserted.
- Reset asserted in MEMWR with mem_ready=1: no MemWrite, next state FETCH, retire_count 0. Counter preset near wrap with CNT_W=4: 15 retires then 1 retire gives 0.
